framing_decoding: RTL
=====================

# framing_decoding

Receive-side counterpart of the transmit framing/encoding chain. Consumes the serial PHY bitstream one bit per valid cycle, hunts for the SFD, de-whitens PHR and PSDU, checks the CRC-16 FCS, and delivers PHR plus payload bytes (FCS stripped) to the MAC-side consumer. It sits between the bit-level demodulator output and the byte-oriented PHR/PSDU interface.

## Interface
- `SFD`, 8'hA7: start-of-frame delimiter, matched LSB-first on raw (unwhitened) bits.
- `PN9_SEED`, 9'h1FF: de-whitening LFSR seed, loaded on SFD match.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `framing_decoding_in`  input  1  serial bit, LSB of each byte first.
- `framing_decoding_in_valid`  input  1  qualifies `framing_decoding_in`; bits are consumed only when high.
- `phr_psdu_out`  output  8  decoded byte (PHR, then payload).
- `phr_psdu_out_valid`  output  1  one-cycle pulse per output byte.
- `frame_end`  output  1  one-cycle pulse on the last payload byte.
- `frame_crc_ok`  output  1  FCS result; meaningful only while `frame_end` is high.

## Operation
- Reset: all outputs 0, state HUNT, shift window 0, LFSR = `PN9_SEED`, CRC = 0, counters 0.
- States: HUNT -> PHR -> PSDU -> HUNT. Only valid cycles advance any state, counter, LFSR, or CRC; invalid cycles freeze everything.
- HUNT: window <= {bit, window[7:1]}; on window == `SFD` (including the bit just shifted in) load LFSR = `PN9_SEED`, CRC = 0, bit counter = 0, go to PHR. Preamble content is not checked.
- De-whitening (PHR and PSDU, including FCS): d = bit ^ lfsr[0]; lfsr <= {lfsr[0]^lfsr[5], lfsr[8:1]}.
- PHR: assemble 8 de-whitened bits LSB-first. Length L = PHR[6:0]; PHR[7] is ignored but passed through. If L < 3, discard silently (no output, no `frame_end`) and return to HUNT with window cleared. Otherwise emit the PHR byte and go to PSDU with byte counter = 0.
- PSDU: L bytes are received. The last 2 are the FCS. Bytes go through a 2-entry delay buffer. When byte k (k >= 2) completes, emit buffered byte k-2. When byte L-1 completes, emit payload byte L-3 and pulse `frame_end`; then return to HUNT with window cleared. FCS bytes are never emitted.
- CRC (CRC-16, reflected polynomial 0x8408, i.e. x^16+x^12+x^5+1, init 0x0000, LSB-first): every de-whitened PSDU bit including FCS is fed through c = crc[0]^d; crc <= (crc>>1) ^ (c ? 16'h8408 : 0). `frame_crc_ok` = (crc == 0) after the final FCS bit.
- Output byte count per accepted frame: exactly 1 + (L-2).
- No timeout: a valid-low gap of any length mid-frame just pauses decoding.
- A new SFD pattern inside PHR or PSDU is data and is not re-matched.

## Timing
- All outputs are registered. A byte appears on `phr_psdu_out` with `phr_psdu_out_valid` = 1 in the cycle after the valid cycle carrying that byte's 8th bit (for payload, the 8th bit of the byte two positions later).
- `frame_end` and `frame_crc_ok` coincide with the final `phr_psdu_out_valid` pulse.
- `phr_psdu_out` holds its last value when not valid. `frame_crc_ok` returns to 0 the cycle after `frame_end`.
- A bit accepted in the cycle after SFD match is the first PHR bit. A bit accepted in the cycle after `frame_end` is hunted.
- Asynchronous reset mid-frame: outputs drop to 0 immediately and any partial frame is lost.

## Configuration
- `FRAMING_DECODING_CRC_EN` defined: CRC register and check are implemented as above.
- Undefined: no CRC logic. `frame_crc_ok` equals `frame_end`, so it is always 1 at frame end. FCS bytes are still received, de-whitened into the LFSR sequence, and stripped.

## Test plan
- Preamble 32 zeros, SFD, whitened PHR = 0x05, payload 0x01 0x02 0x03 plus a correct FCS, continuous valid -> bytes 0x05, 0x01, 0x02, 0x03; `frame_end` = 1 with `frame_crc_ok` = 1 on byte 0x03.
- Same frame with payload bit 0 of 0x02 flipped before whitening -> bytes 0x05, 0x01, 0x03, 0x03; `frame_crc_ok` = 0.
- PHR = 0x02 frame followed by a valid frame -> no output for the first, second decoded correctly.
- Good frame with random valid gaps (30% low duty) -> byte sequence and flags identical to the continuous case.
- Assert `reset_n` low during the 2nd payload byte, then send a new good frame -> outputs 0 during reset, new frame decoded fully with `frame_crc_ok` = 1.
- Macro undefined, corrupted frame from scenario 2 -> same bytes, `frame_crc_ok` = 1.

Source files
------------

// File: rtl/framing_decoding.sv
// framing_decoding: serial PHY bit receiver -- SFD hunt, PN9 de-whitening, CRC-16 FCS check, PHR+payload byte output
// Ports: clk, reset_n (async active-low); framing_decoding_in/_valid serial bit input (LSB first);
//        phr_psdu_out/_valid decoded byte pulse; frame_end last payload byte pulse; frame_crc_ok FCS result.
// Build option: define FRAMING_DECODING_CRC_EN to implement the FCS check; otherwise frame_crc_ok mirrors frame_end.
module framing_decoding (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       framing_decoding_in,
    input  logic       framing_decoding_in_valid,
    output logic [7:0] phr_psdu_out,
    output logic       phr_psdu_out_valid,
    output logic       frame_end,
    output logic       frame_crc_ok
);
    localparam logic [7:0] SFD = 8'hA7;
    localparam logic [8:0] PN9_SEED = 9'h1FF;
    typedef enum logic [1:0] {HUNT, PHR, PSDU} state_t;
    state_t r_state, w_state_nxt;
    logic [7:0] r_win, r_b0, r_b1, w_win, w_byte, w_out;
    logic [6:0] r_sh, r_bytecnt, r_len;
    logic [8:0] r_lfsr;
    logic [2:0] r_bitcnt;
    logic w_d, w_byte_done, w_sfd, w_short, w_last, w_out_valid, w_end, w_crc_ok;
    assign w_win = {framing_decoding_in, r_win[7:1]};
    assign w_d = framing_decoding_in ^ r_lfsr[0];
    assign w_byte = {w_d, r_sh};
    assign w_sfd = framing_decoding_in_valid && r_state == HUNT && w_win == SFD;
    assign w_byte_done = framing_decoding_in_valid && r_state != HUNT && r_bitcnt == 3'd7;
    assign w_short = w_byte[6:0] < 7'd3;
    assign w_last = r_bytecnt == r_len - 7'd1;
`ifdef FRAMING_DECODING_CRC_EN
    logic [15:0] r_crc, w_crc;
    assign w_crc = (r_crc >> 1) ^ ((r_crc[0] ^ w_d) ? 16'h8408 : 16'h0000);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            r_crc <= 16'h0000;
        else if (framing_decoding_in_valid)
            r_crc <= w_sfd ? 16'h0000 : (r_state == PSDU ? w_crc : r_crc);
    assign w_crc_ok = w_end && w_crc == 16'h0000;
`else
    assign w_crc_ok = w_end;
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            r_state <= HUNT;
        else
            r_state <= w_state_nxt;
    always_comb begin
        w_state_nxt = r_state;
        if (w_sfd)
            w_state_nxt = PHR;
        else if (w_byte_done && r_state == PHR)
            w_state_nxt = w_short ? HUNT : PSDU;
        else if (w_byte_done && r_state == PSDU && w_last)
            w_state_nxt = HUNT;
    end
    // Payload leaves through a 2-byte delay so the two FCS bytes are never emitted.
    always_comb begin
        w_out_valid = w_byte_done && (r_state == PHR ? !w_short : r_bytecnt >= 7'd2);
        w_out = r_state == PHR ? w_byte : r_b1;
        w_end = w_byte_done && r_state == PSDU && w_last;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_win <= 8'h00;
            r_lfsr <= PN9_SEED;
            r_bitcnt <= 3'd0;
            r_sh <= 7'h00;
            r_len <= 7'd0;
            r_bytecnt <= 7'd0;
            r_b0 <= 8'h00;
            r_b1 <= 8'h00;
        end else if (framing_decoding_in_valid) begin
            // Window is cleared outside HUNT so each new hunt starts from an empty window.
            r_win <= (r_state == HUNT && !w_sfd) ? w_win : 8'h00;
            r_lfsr <= w_sfd ? PN9_SEED : (r_state == HUNT ? r_lfsr : {r_lfsr[0] ^ r_lfsr[5], r_lfsr[8:1]});
            r_bitcnt <= r_state == HUNT ? 3'd0 : r_bitcnt + 3'd1;
            if (r_state != HUNT)
                r_sh <= w_byte[7:1];
            if (w_byte_done && r_state == PHR) begin
                r_len <= w_byte[6:0];
                r_bytecnt <= 7'd0;
            end
            if (w_byte_done && r_state == PSDU) begin
                r_bytecnt <= r_bytecnt + 7'd1;
                r_b1 <= r_b0;
                r_b0 <= w_byte;
            end
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            phr_psdu_out <= 8'h00;
            phr_psdu_out_valid <= 1'b0;
            frame_end <= 1'b0;
            frame_crc_ok <= 1'b0;
        end else begin
            phr_psdu_out <= w_out_valid ? w_out : phr_psdu_out;
            phr_psdu_out_valid <= w_out_valid;
            frame_end <= w_end;
            frame_crc_ok <= w_crc_ok;
        end
endmodule
